// File: rtl/spu_ctrl_pkg.sv
// spu_ctrl_pkg: shared constants, controller state type and source-busy helper
package spu_ctrl_pkg;
    localparam int NREG = 128;
    localparam int REGW = 7;
    localparam int LATW = 3;
    typedef enum logic {RUN, FLUSH} ctrl_state_t;
    // Lanes 0..2 of v carry ra/rb/rc scoreboard values; lane 3 (rt) is ignored here.
    function automatic logic srcs_busy(input logic [2:0] mask, input logic [3:0][LATW-1:0] v);
        return |(mask & {v[2] != '0, v[1] != '0, v[0] != '0});
    endfunction
endpackage

// File: rtl/spu_issue_ctrl_if.sv
// spu_issue_ctrl_if: ID-stage instruction pair, branch resolve and IF/ID control bundle
interface spu_issue_ctrl_if;
    import spu_ctrl_pkg::*;
    logic            id_valid_even, id_valid_odd;
    logic [REGW-1:0] id_even_ra, id_even_rb, id_even_rc, id_even_rt;
    logic [REGW-1:0] id_odd_ra, id_odd_rb, id_odd_rc, id_odd_rt;
    logic [2:0]      id_even_use, id_odd_use;
    logic            id_even_wr, id_odd_wr;
    logic [LATW-1:0] id_even_lat, id_odd_lat;
    logic            br_taken;
    logic            issue_even, issue_odd;
    logic            stallEven, stallOdd, flushEven, flushOdd;
    logic            pc_stall, ctrl_state;
    logic [15:0]     stall_cnt;
    modport master (
        output id_valid_even, id_valid_odd, id_even_ra, id_even_rb, id_even_rc, id_even_rt,
               id_odd_ra, id_odd_rb, id_odd_rc, id_odd_rt, id_even_use, id_odd_use,
               id_even_wr, id_odd_wr, id_even_lat, id_odd_lat, br_taken,
        input  issue_even, issue_odd, stallEven, stallOdd, flushEven, flushOdd,
               pc_stall, ctrl_state, stall_cnt
    );
    modport slave (
        input  id_valid_even, id_valid_odd, id_even_ra, id_even_rb, id_even_rc, id_even_rt,
               id_odd_ra, id_odd_rb, id_odd_rc, id_odd_rt, id_even_use, id_odd_use,
               id_even_wr, id_odd_wr, id_even_lat, id_odd_lat, br_taken,
        output issue_even, issue_odd, stallEven, stallOdd, flushEven, flushOdd,
               pc_stall, ctrl_state, stall_cnt
    );
endinterface

// File: rtl/spu_scoreboard.sv
// spu_scoreboard: per-register countdown of cycles until the result is readable
module spu_scoreboard
    import spu_ctrl_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic [3:0][REGW-1:0]  rd_even,
    input  logic [3:0][REGW-1:0]  rd_odd,
    output logic [3:0][LATW-1:0]  val_even,
    output logic [3:0][LATW-1:0]  val_odd,
    input  logic                  ld_even,
    input  logic [REGW-1:0]       ld_even_idx,
    input  logic [LATW-1:0]       ld_even_lat,
    input  logic                  ld_odd,
    input  logic [REGW-1:0]       ld_odd_idx,
    input  logic [LATW-1:0]       ld_odd_lat
);
    logic [LATW-1:0] sb [NREG];
    always_comb
        for (int i = 0; i < 4; i++) begin
            val_even[i] = sb[rd_even[i]];
            val_odd[i]  = sb[rd_odd[i]];
        end
    always_ff @(posedge clk or negedge reset)
        if (!reset)
            for (int r = 0; r < NREG; r++) sb[r] <= '0;
        else
            for (int r = 0; r < NREG; r++)
                sb[r] <= (ld_even && ld_even_idx == REGW'(r)) ? ld_even_lat :
                         (ld_odd && ld_odd_idx == REGW'(r))   ? ld_odd_lat  :
                         (sb[r] != '0) ? sb[r] - 1'b1 : '0;
endmodule

// File: rtl/spu_issue_ctrl.sv
// spu_issue_ctrl: dual-issue hazard check, hold/split/issue decision and post-branch flush sequencing
module spu_issue_ctrl
    import spu_ctrl_pkg::*;
#(
    parameter int FLUSH_CYCLES = 2
) (
    input logic clk,
    input logic reset,
    spu_issue_ctrl_if.slave bus
);
    localparam int CW = FLUSH_CYCLES > 1 ? $clog2(FLUSH_CYCLES) : 1;
    ctrl_state_t          state;
    logic [CW-1:0]        cnt;
    logic [15:0]          scnt;
    logic [3:0][LATW-1:0] sb_e, sb_o;
    logic [2:0]           dep_o;
    logic                 haz_e, haz_o, go, hold, split;

    spu_scoreboard u_sb (
        .clk         (clk),
        .reset       (reset),
        .rd_even     ({bus.id_even_rt, bus.id_even_rc, bus.id_even_rb, bus.id_even_ra}),
        .rd_odd      ({bus.id_odd_rt, bus.id_odd_rc, bus.id_odd_rb, bus.id_odd_ra}),
        .val_even    (sb_e),
        .val_odd     (sb_o),
        .ld_even     (bus.issue_even & bus.id_even_wr),
        .ld_even_idx (bus.id_even_rt),
        .ld_even_lat (bus.id_even_lat),
        .ld_odd      (bus.issue_odd & bus.id_odd_wr),
        .ld_odd_idx  (bus.id_odd_rt),
        .ld_odd_lat  (bus.id_odd_lat)
    );

    assign dep_o = bus.id_odd_use & {bus.id_odd_rc == bus.id_even_rt,
                                     bus.id_odd_rb == bus.id_even_rt,
                                     bus.id_odd_ra == bus.id_even_rt};
    assign haz_e = bus.id_valid_even & (srcs_busy(bus.id_even_use, sb_e) |
                   (bus.id_even_wr & (sb_e[3] > bus.id_even_lat)));
    // Odd also waits on the even partner: RAW through even_rt and same-cycle WAW.
    assign haz_o = bus.id_valid_odd & (srcs_busy(bus.id_odd_use, sb_o) |
                   (bus.id_odd_wr & (sb_o[3] > bus.id_odd_lat)) |
                   (bus.id_valid_even & bus.id_even_wr &
                    ((|dep_o) | (bus.id_odd_wr & bus.id_even_rt == bus.id_odd_rt))));

    // Decision outputs are forced low while reset is asserted.
    assign go    = reset & state == RUN & !bus.br_taken;
    assign hold  = go & haz_e;
    assign split = go & !haz_e & haz_o;

    assign bus.issue_even = go & !haz_e & bus.id_valid_even;
    assign bus.issue_odd  = go & !haz_e & !haz_o & bus.id_valid_odd;
    assign bus.flushOdd   = reset & (state == FLUSH | bus.br_taken);
    assign bus.flushEven  = bus.flushOdd | split;
    assign bus.stallEven  = hold | split;
    assign bus.stallOdd   = hold | split;
    assign bus.pc_stall   = hold | split;
    assign bus.ctrl_state = state == FLUSH;
    assign bus.stall_cnt  = scnt;

    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            state <= RUN;
            cnt   <= '0;
            scnt  <= '0;
        end else begin
            if (bus.br_taken) begin
                state <= FLUSH;
                cnt   <= CW'(FLUSH_CYCLES - 1);
            end else if (state == FLUSH) begin
                state <= cnt == '0 ? RUN : FLUSH;
                cnt   <= cnt == '0 ? '0 : cnt - 1'b1;
            end
            if ((hold | split) && scnt != 16'hFFFF) scnt <= scnt + 16'd1;
        end
endmodule

// File: tb/tb_spu_issue_ctrl.sv
// tb_spu_issue_ctrl: directed vectors for spu_issue_ctrl with hand-computed expectations
module tb_spu_issue_ctrl;
    import spu_ctrl_pkg::*;
    logic clk = 0;
    logic reset = 0;
    int checks = 0;
    int errors = 0;

    spu_issue_ctrl_if bus();
    spu_issue_ctrl dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    // Packed as {issue_even, issue_odd, stallEven, stallOdd, flushEven, flushOdd, pc_stall, ctrl_state}
    function automatic logic [7:0] ctl();
        return {bus.issue_even, bus.issue_odd, bus.stallEven, bus.stallOdd,
                bus.flushEven, bus.flushOdd, bus.pc_stall, bus.ctrl_state};
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input string tag, input logic [7:0] e_ctl, input logic [15:0] e_cnt);
        #2;
        chk({tag, ".ctl"}, 32'(ctl()), 32'(e_ctl));
        chk({tag, ".cnt"}, 32'(bus.stall_cnt), 32'(e_cnt));
        @(posedge clk);
        #1;
    endtask

    task automatic set_even(input logic v, input logic [6:0] ra, input logic [6:0] rb, input logic [6:0] rc,
                            input logic [2:0] m, input logic [6:0] rt, input logic wr, input logic [2:0] lat);
        bus.id_valid_even = v;
        bus.id_even_ra = ra;
        bus.id_even_rb = rb;
        bus.id_even_rc = rc;
        bus.id_even_use = m;
        bus.id_even_rt = rt;
        bus.id_even_wr = wr;
        bus.id_even_lat = lat;
    endtask

    task automatic set_odd(input logic v, input logic [6:0] ra, input logic [6:0] rb, input logic [6:0] rc,
                           input logic [2:0] m, input logic [6:0] rt, input logic wr, input logic [2:0] lat);
        bus.id_valid_odd = v;
        bus.id_odd_ra = ra;
        bus.id_odd_rb = rb;
        bus.id_odd_rc = rc;
        bus.id_odd_use = m;
        bus.id_odd_rt = rt;
        bus.id_odd_wr = wr;
        bus.id_odd_lat = lat;
    endtask

    task automatic idle();
        set_even(0, 0, 0, 0, 3'b000, 0, 0, 3'd1);
        set_odd(0, 0, 0, 0, 3'b000, 0, 0, 3'd1);
    endtask

    initial begin
        idle();
        bus.br_taken = 0;
        #1;
        step("rst_idle", 8'b00000000, 0);
        reset = 1;
        set_even(1, 1, 0, 0, 3'b001, 5, 1, 3'd3);
        set_odd(1, 2, 0, 0, 3'b001, 6, 1, 3'd4);
        step("pair", 8'b11000000, 0);
        bus.br_taken = 1;
        reset = 0;
        step("rst_mid", 8'b00000000, 0);
        reset = 1;
        bus.br_taken = 0;
        set_even(1, 5, 0, 0, 3'b001, 0, 0, 3'd1);
        set_odd(1, 6, 0, 0, 3'b001, 0, 0, 3'd1);
        step("rst_clr", 8'b11000000, 0);

        set_even(1, 1, 0, 0, 3'b001, 5, 1, 3'd2);
        set_odd(1, 2, 0, 0, 3'b001, 20, 1, 3'd1);
        step("a_issue", 8'b11000000, 0);
        set_even(1, 5, 0, 0, 3'b001, 30, 1, 3'd1);
        set_odd(1, 3, 0, 0, 3'b001, 0, 0, 3'd1);
        step("a_hold1", 8'b00110010, 0);
        step("a_hold2", 8'b00110010, 1);
        step("a_go", 8'b11000000, 2);

        set_even(1, 0, 0, 0, 3'b000, 10, 1, 3'd1);
        set_odd(1, 0, 10, 0, 3'b010, 11, 1, 3'd1);
        step("b_split", 8'b10111010, 2);
        set_even(0, 0, 0, 0, 3'b000, 0, 0, 3'd1);
        step("b_oddhold", 8'b00111010, 3);
        step("b_oddgo", 8'b01000000, 4);

        set_odd(0, 0, 0, 0, 3'b000, 0, 0, 3'd1);
        set_even(1, 0, 0, 0, 3'b000, 7, 1, 3'd3);
        step("c_ld", 8'b10000000, 4);
        set_even(1, 0, 0, 0, 3'b000, 7, 1, 3'd2);
        step("c_waw", 8'b00110010, 4);
        step("c_go", 8'b10000000, 5);
        set_even(1, 7, 0, 0, 3'b001, 0, 0, 3'd1);
        step("c_rd1", 8'b00110010, 5);
        step("c_rd2", 8'b00110010, 6);
        step("c_rd3", 8'b10000000, 7);

        set_even(1, 0, 0, 0, 3'b000, 40, 1, 3'd5);
        step("d_ld", 8'b10000000, 7);
        set_even(1, 40, 0, 0, 3'b001, 0, 0, 3'd1);
        bus.br_taken = 1;
        step("d_br", 8'b00001100, 7);
        bus.br_taken = 0;
        step("d_fl1", 8'b00001101, 7);
        step("d_fl2", 8'b00001101, 7);
        idle();
        step("d_run", 8'b00000000, 7);

        bus.br_taken = 1;
        step("e_br1", 8'b00001100, 7);
        bus.br_taken = 0;
        step("e_fl1", 8'b00001101, 7);
        bus.br_taken = 1;
        step("e_br2", 8'b00001101, 7);
        bus.br_taken = 0;
        step("e_fl2", 8'b00001101, 7);
        step("e_fl3", 8'b00001101, 7);
        step("e_run", 8'b00000000, 7);

        set_even(1, 0, 0, 0, 3'b000, 50, 1, 3'd7);
        step("f_ld", 8'b10000000, 7);
        idle();
        bus.br_taken = 1;
        step("f_br", 8'b00001100, 7);
        bus.br_taken = 0;
        reset = 0;
        step("f_rst", 8'b00000000, 0);
        reset = 1;
        set_even(1, 50, 0, 0, 3'b001, 0, 0, 3'd1);
        step("f_clr", 8'b10000000, 0);

        set_even(1, 0, 0, 0, 3'b000, 60, 1, 3'd1);
        set_odd(1, 60, 0, 0, 3'b001, 0, 0, 3'd1);
        repeat (65536) @(posedge clk);
        #1;
        step("s_sat", 8'b10111010, 16'hFFFF);
        step("s_sat2", 8'b10111010, 16'hFFFF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/spu_issue_ctrl.md
# spu_issue_ctrl

Dual-issue hazard and issue controller for the SPU front end. Each cycle it examines the instruction pair held in the IF/ID register (even slot older, odd slot younger) against a register scoreboard and decides whether to issue both, issue even only (split), or hold both. It drives the IF/ID stall/flush controls and the fetch-freeze line, and sequences multi-cycle flushes after a taken branch.

## Interface
- NREG, 128, architectural registers tracked by the scoreboard
- REGW, 7, register-index width
- LATW, 3, result-latency width
- FLUSH_CYCLES, 2, cycles both IF/ID slots are flushed after a taken branch (≥1)

- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-low; asserted (0) clears all state immediately
- id_valid_even / id_valid_odd  in  1  slot holds a real instruction (word 0 decodes invalid)
- id_even_ra/rb/rc, id_odd_ra/rb/rc  in  REGW  source register indices
- id_even_use, id_odd_use  in  3  source-used mask {rc,rb,ra}
- id_even_rt, id_odd_rt  in  REGW  destination register
- id_even_wr, id_odd_wr  in  1  instruction writes rt
- id_even_lat, id_odd_lat  in  LATW  result latency, 1..7
- br_taken  in  1  branch resolved taken (odd pipe), one-cycle pulse
- issue_even, issue_odd  out  1  slot advances to RF stage this cycle
- stallEven, stallOdd, flushEven, flushOdd  out  1  IF/ID slot controls (flush overrides stall in IF/ID)
- pc_stall  out  1  freeze fetch PC and IF outputs
- ctrl_state  out  1  0=RUN, 1=FLUSH
- stall_cnt  out  16  saturating count of hazard-stall cycles

## Operation
- Scoreboard sb[NREG], LATW bits each; register readable iff sb[r]==0.
- hazE = valid_even & ( any used even source with sb≠0 | (even_wr & sb[even_rt] > even_lat) ).
- hazO = valid_odd & ( any used odd source with sb≠0 | (odd_wr & sb[odd_rt] > odd_lat) | (valid_even & even_wr & odd uses a source == even_rt) | (valid_even & even_wr & odd_wr & even_rt==odd_rt) ).
- Decision in RUN, priority order:
  - br_taken: flushEven=flushOdd=1, no issue, enter FLUSH, counter=FLUSH_CYCLES-1.
  - hazE: hold — stallEven=stallOdd=pc_stall=1, no issue (in-order: odd never passes even).
  - hazO & !hazE: split — issue_even=1, flushEven=1, stallEven=stallOdd=1, pc_stall=1.
  - else: issue_even=valid_even, issue_odd=valid_odd, no stall/flush.
- FLUSH: flushEven=flushOdd=1, no issue, pc_stall=0; counter decrements; at 0 → RUN. br_taken in FLUSH reloads counter to FLUSH_CYCLES-1.
- Scoreboard update each cycle: every nonzero entry decrements; issuing writer loads sb[rt]<=lat (load overrides decrement). Even and odd never load the same rt in one cycle (excluded by hazO).
- Issued instructions are never cancelled here; scoreboard entries from wrong-path instructions drain naturally (conservative).
- stall_cnt increments on hold and split cycles, saturates at 16'hFFFF; flush cycles not counted.

## Timing
- Reset (0): all outputs 0, sb all 0, state RUN, counter 0, stall_cnt 0; asynchronous assert, synchronous-edge release.
- Decision outputs combinational from registered sb/state and ID inputs; same-cycle to IF/ID.
- Writer issued at cycle t with lat L: sb=L at t+1, dependent may issue at t+L+1.
- Split at t: odd slot held; at t+1 even slot empty, odd re-evaluated normally.
- br_taken in same cycle as hazard: flush wins, no stall_cnt increment.
- Reset mid-FLUSH: returns to RUN, counter and sb cleared.

## Structure
- Package spu_ctrl_pkg: ctrl_state_t enum {RUN, FLUSH}, REGW, LATW, NREG constants.
- Sub-module spu_scoreboard: sb array, two read-port sets per slot (3 sources + rt), two load ports, decrement logic; controller holds FSM, hazard logic, counter.

## Test plan
- Reset low mid-traffic → all outputs 0; release, independent valid pair → issue_even=issue_odd=1, stalls 0.
- Even writes r5 lat 2 issued at t; next pair even reads r5 → hold at t+1,t+2, issue at t+3, stall_cnt=2.
- Pair: even writes r10 lat 1, odd reads r10 → t split (issue_even=1, flushEven=1, stallOdd=1); odd holds t+1, issues t+2.
- sb[7]=3 in flight, even writes r7 lat 2 → hold one cycle, issue next; sb[7]=2 after issue.
- br_taken while hazE → flushEven=flushOdd=1 for 2 cycles, no issue, ctrl_state=1 then RUN; stall_cnt unchanged.
- Second br_taken during FLUSH → flush extends to 2 cycles from second pulse; reset during FLUSH → RUN, sb cleared.
